// File: rtl/rs232_tx_arb.sv
// rs232_tx_arb: message-level round-robin arbiter sharing one rs232_tx_ctrl
// among NREQ byte-stream requesters. A grant lasts until the owner's req_last
// byte is taken, or until the watchdog sees the owner go quiet for too long.
// Pure pass-through on the rdy/val/bits handshake; no buffering.
module rs232_tx_arb #(
   parameter  int NREQ    = 4,
   parameter  int TIMEOUT = 65535,
   localparam int OW      = (NREQ > 1) ? $clog2(NREQ) : 1,
   localparam int CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      i_req_val,
   input  logic [NREQ-1:0][7:0] i_req_bits,
   input  logic [NREQ-1:0]      i_req_last,
   output logic [NREQ-1:0]      o_req_rdy,
   input  logic                 i_tx_rdy,
   output logic                 o_tx_val,
   output logic [7:0]           o_tx_bits,
   output logic [OW-1:0]        o_owner,
   output logic                 o_busy,
   output logic                 o_timeout_evt
);

   typedef enum logic {S_IDLE, S_LOCKED} state_t;

   state_t        r_state, w_state_nxt;
   logic [OW-1:0] r_ptr, w_ptr_nxt;
   logic [OW-1:0] r_owner, w_owner_nxt;
   logic [OW-1:0] w_sel, w_own_inc;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic          r_evt, w_evt_nxt;
   logic          w_found, w_locked, w_own_val, w_xfer;

   assign w_locked  = (r_state == S_LOCKED);
   assign w_own_val = i_req_val[r_owner];
   assign w_xfer    = w_locked && w_own_val && i_tx_rdy;

   // Next round-robin start point: owner + 1, wrapping at NREQ.
   always_comb begin
      w_own_inc = r_owner + 1'b1;
      if (int'(r_owner) == NREQ - 1) w_own_inc = '0;
   end

   // Circular priority search starting at r_ptr; the lowest offset wins, so
   // iterate from the farthest offset down and let nearer hits overwrite.
   always_comb begin
      logic [OW-1:0] v_idx;
      w_found = 1'b0;
      w_sel   = '0;
      v_idx   = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         v_idx = OW'((int'(r_ptr) + k) % NREQ);
         if (i_req_val[v_idx]) begin
            w_found = 1'b1;
            w_sel   = v_idx;
         end
      end
   end

   // Lock FSM next state plus pointer, owner, watchdog counter and event.
   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_owner_nxt = r_owner;
      w_cnt_nxt   = r_cnt;
      w_evt_nxt   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_state_nxt = S_LOCKED;
               w_owner_nxt = w_sel;
               w_cnt_nxt   = '0;
            end
         end
         S_LOCKED: begin
            if (w_xfer) begin
               w_cnt_nxt = '0;
               if (i_req_last[r_owner]) begin
                  w_state_nxt = S_IDLE;
                  w_ptr_nxt   = w_own_inc;
               end
            end else if (!w_own_val) begin
               // Owner has nothing to send; backpressure alone never counts.
               if (TIMEOUT != 0 && (int'(r_cnt) + 1 >= TIMEOUT - 1)) begin
                  w_state_nxt = S_IDLE;
                  w_ptr_nxt   = w_own_inc;
                  w_evt_nxt   = 1'b1;
                  w_cnt_nxt   = '0;
               end else if (r_cnt != {CW{1'b1}}) begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_ptr   <= '0;
         r_owner <= '0;
         r_cnt   <= '0;
         r_evt   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_owner <= w_owner_nxt;
         r_cnt   <= w_cnt_nxt;
         r_evt   <= w_evt_nxt;
      end
   end

   // Combinational steering of the owner's handshake onto the transmitter.
   always_comb begin
      o_tx_val  = w_locked && w_own_val;
      o_tx_bits = i_req_bits[r_owner];
      o_req_rdy = '0;
      for (int i = 0; i < NREQ; i++)
         o_req_rdy[i] = w_locked && (r_owner == OW'(i)) && i_tx_rdy;
   end

   assign o_owner       = r_owner;
   assign o_busy        = w_locked;
   assign o_timeout_evt = r_evt;

endmodule

// File: tb/tb_rs232_tx_arb.sv
// Bench for rs232_tx_arb: a vector table for cycle-by-cycle arbitration, plus
// hand sequences for long messages, lock hold, watchdog, backpressure, reset.
// Instance a uses TIMEOUT=16, instance b the default (watchdog effectively off).
module tb_rs232_tx_arb;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [3:0]      val, last;
   logic [3:0][7:0] bits;
   logic            tx_rdy;

   logic [3:0] rr_a, rr_b;
   logic       txv_a, txv_b, busy_a, busy_b, evt_a, evt_b;
   logic [7:0] txb_a, txb_b;
   logic [1:0] own_a, own_b;

   rs232_tx_arb #(.NREQ(4), .TIMEOUT(16)) u_a (
      .clk(clk), .rst(rst), .i_req_val(val), .i_req_bits(bits), .i_req_last(last),
      .o_req_rdy(rr_a), .i_tx_rdy(tx_rdy), .o_tx_val(txv_a), .o_tx_bits(txb_a),
      .o_owner(own_a), .o_busy(busy_a), .o_timeout_evt(evt_a));

   rs232_tx_arb #(.NREQ(4)) u_b (
      .clk(clk), .rst(rst), .i_req_val(val), .i_req_bits(bits), .i_req_last(last),
      .o_req_rdy(rr_b), .i_tx_rdy(tx_rdy), .o_tx_val(txv_b), .o_tx_bits(txb_b),
      .o_owner(own_b), .o_busy(busy_b), .o_timeout_evt(evt_b));

   typedef struct {
      logic       rst;
      logic [3:0] val;
      logic [3:0] last;
      logic [7:0] b;      // requester i drives b+i
      logic       rdy;
      logic       busy;
      logic [1:0] own;
      logic       txv;
      logic [7:0] txb;    // checked only when txv expected
      logic [3:0] rr;
      logic       evt;
   } vec_t;

   vec_t tbl[$];
   int   nerr = 0;
   int   nchk = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      #3;
   endtask

   task automatic clr_in();
      val = '0; last = '0; bits = '0; tx_rdy = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clr_in();
      nxt();
      nxt();
      rst = 1'b0;
   endtask

   initial begin
      logic [7:0] got[$];
      logic [7:0] msg[3];
      int         idx[4];
      int         k;
      logic       bad, multi, done;
      vec_t       v;

      //             rst   val    last   b      rdy   busy  own   txv   txb    rr     evt
      tbl.push_back('{1'b0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 4'h0, 1'b0});
      tbl.push_back('{1'b0, 4'hF, 4'h0, 8'h10, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 4'h0, 1'b0});
      tbl.push_back('{1'b0, 4'hF, 4'h0, 8'h10, 1'b1, 1'b1, 2'd0, 1'b1, 8'h10, 4'h1, 1'b0});
      tbl.push_back('{1'b0, 4'hF, 4'hF, 8'h20, 1'b1, 1'b1, 2'd0, 1'b1, 8'h20, 4'h1, 1'b0});
      tbl.push_back('{1'b0, 4'hF, 4'h0, 8'h30, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 4'h0, 1'b0});
      tbl.push_back('{1'b0, 4'hF, 4'h0, 8'h30, 1'b0, 1'b1, 2'd1, 1'b1, 8'h31, 4'h0, 1'b0});
      tbl.push_back('{1'b0, 4'hF, 4'h0, 8'h30, 1'b1, 1'b1, 2'd1, 1'b1, 8'h31, 4'h2, 1'b0});
      tbl.push_back('{1'b0, 4'hF, 4'hF, 8'h40, 1'b1, 1'b1, 2'd1, 1'b1, 8'h41, 4'h2, 1'b0});
      tbl.push_back('{1'b0, 4'hB, 4'h0, 8'h50, 1'b1, 1'b0, 2'd1, 1'b0, 8'h00, 4'h0, 1'b0});
      tbl.push_back('{1'b0, 4'hB, 4'hF, 8'h50, 1'b1, 1'b1, 2'd3, 1'b1, 8'h53, 4'h8, 1'b0});
      tbl.push_back('{1'b0, 4'hA, 4'h0, 8'h60, 1'b1, 1'b0, 2'd3, 1'b0, 8'h00, 4'h0, 1'b0});
      tbl.push_back('{1'b0, 4'hA, 4'hF, 8'h60, 1'b1, 1'b1, 2'd1, 1'b1, 8'h61, 4'h2, 1'b0});
      tbl.push_back('{1'b0, 4'h0, 4'h0, 8'h00, 1'b1, 1'b0, 2'd1, 1'b0, 8'h00, 4'h0, 1'b0});

      do_reset();
      for (int n = 0; n < tbl.size(); n++) begin
         v = tbl[n];
         nxt();
         rst = v.rst; val = v.val; last = v.last; tx_rdy = v.rdy;
         for (int i = 0; i < 4; i++) bits[i] = 8'(v.b + 8'(i));
         mid();
         chk($sformatf("v%0d_busy", n), 32'(busy_a), 32'(v.busy));
         chk($sformatf("v%0d_owner", n), 32'(own_a), 32'(v.own));
         chk($sformatf("v%0d_txval", n), 32'(txv_a), 32'(v.txv));
         chk($sformatf("v%0d_reqrdy", n), 32'(rr_a), 32'(v.rr));
         chk($sformatf("v%0d_evt", n), 32'(evt_a), 32'(v.evt));
         if (v.txv) chk($sformatf("v%0d_txbits", n), 32'(txb_a), 32'(v.txb));
      end

      // Single 3-byte message from requester 2, tx_rdy pulsing every 20 cycles.
      do_reset();
      msg = '{8'h41, 8'h42, 8'h0A};
      got.delete();
      k = 0;
      for (int c = 0; c < 300 && k < 3; c++) begin
         nxt();
         tx_rdy = (c % 20 == 19);
         val = 4'b0100; bits[2] = msg[k]; last[2] = (k == 2);
         mid();
         if (rr_a[2]) begin
            got.push_back(txb_a);
            k++;
         end
      end
      chk("sm_count", 32'(got.size()), 32'd3);
      for (int i = 0; i < 3; i++)
         if (i < got.size()) chk($sformatf("sm_byte%0d", i), 32'(got[i]), 32'(msg[i]));
      nxt();
      val = 4'b1001; last = '0; tx_rdy = 1'b0;
      mid();
      chk("sm_busy_fall", 32'(busy_a), 32'd0);
      nxt();
      mid();
      chk("sm_ptr3_busy", 32'(busy_a), 32'd1);
      chk("sm_ptr3_owner", 32'(own_a), 32'd3);

      // All four requesters each send a 2-byte message simultaneously.
      do_reset();
      got.delete();
      for (int i = 0; i < 4; i++) idx[i] = 0;
      multi = 1'b0;
      done = 1'b0;
      for (int c = 0; c < 60 && !done; c++) begin
         nxt();
         tx_rdy = 1'b1;
         for (int i = 0; i < 4; i++) begin
            val[i]  = (idx[i] < 2);
            bits[i] = 8'(i * 16 + idx[i]);
            last[i] = (idx[i] == 1);
         end
         mid();
         if ($countones(rr_a) > 1) multi = 1'b1;
         for (int i = 0; i < 4; i++)
            if (rr_a[i] && val[i]) begin
               got.push_back(txb_a);
               idx[i]++;
            end
         done = (idx[0] == 2) && (idx[1] == 2) && (idx[2] == 2) && (idx[3] == 2);
      end
      chk("rr_count", 32'(got.size()), 32'd8);
      chk("rr_onehot", 32'(multi), 32'd0);
      for (int i = 0; i < 8; i++)
         if (i < got.size()) chk($sformatf("rr_order%0d", i), 32'(got[i]), 32'((i / 2) * 16 + i % 2));

      // Lock hold on instance b: requester 1 pauses 100 cycles mid-message.
      do_reset();
      nxt(); val = 4'b0010; tx_rdy = 1'b1; bits[1] = 8'h51; bits[0] = 8'h01;
      mid();
      nxt(); val = 4'b0011;
      mid();
      chk("lh_first", 32'(rr_b), 32'h2);
      bad = 1'b0;
      for (int c = 0; c < 100; c++) begin
         nxt(); val = 4'b0001;
         mid();
         if (rr_b[0] || !busy_b || own_b != 2'd1 || txv_b) bad = 1'b1;
      end
      chk("lh_hold", 32'(bad), 32'd0);
      nxt(); val = 4'b0011; bits[1] = 8'h52; last = 4'b0010;
      mid();
      chk("lh_last_rdy", 32'(rr_b), 32'h2);
      chk("lh_last_bits", 32'(txb_b), 32'h52);
      nxt(); val = 4'b0001; last = '0;
      mid();
      chk("lh_release", 32'(busy_b), 32'd0);
      nxt();
      mid();
      chk("lh_next_owner", 32'(own_b), 32'd0);
      chk("lh_next_rdy", 32'(rr_b), 32'h1);

      // Watchdog: owner 3 drops req_val after its first byte.
      do_reset();
      nxt(); val = 4'b1000; tx_rdy = 1'b1; bits[3] = 8'h77;
      mid();
      nxt();
      mid();
      chk("wd_first", 32'(rr_a), 32'h8);
      bad = 1'b0;
      for (int c = 2; c <= 16; c++) begin
         nxt(); val = 4'b0001;
         mid();
         if (!busy_a || evt_a || own_a != 2'd3) bad = 1'b1;
      end
      chk("wd_held", 32'(bad), 32'd0);
      nxt();
      mid();
      chk("wd_busy", 32'(busy_a), 32'd0);
      chk("wd_evt", 32'(evt_a), 32'd1);
      chk("wd_b_no_timeout", 32'(busy_b), 32'd1);
      nxt();
      mid();
      chk("wd_evt_pulse", 32'(evt_a), 32'd0);
      chk("wd_regrant", 32'(busy_a), 32'd1);
      chk("wd_owner0", 32'(own_a), 32'd0);

      // Backpressure: tx_rdy low for 1000 cycles, owner keeps req_val.
      do_reset();
      nxt(); val = 4'b0100; bits[2] = 8'h33;
      mid();
      bad = 1'b0;
      for (int c = 0; c < 1000; c++) begin
         nxt();
         mid();
         if (!busy_a || evt_a || own_a != 2'd2 || !txv_a || rr_a != 4'h0) bad = 1'b1;
      end
      chk("bp_hold", 32'(bad), 32'd0);
      nxt(); tx_rdy = 1'b1; last = 4'b0100;
      mid();
      chk("bp_accept", 32'(rr_a), 32'h4);

      // Reset while requester 2 is mid-message, with ptr previously at 2.
      do_reset();
      nxt(); val = 4'b0010; tx_rdy = 1'b1; last = 4'b0010;
      mid();
      nxt();
      mid();
      nxt(); val = 4'b0100; last = '0;
      mid();
      nxt();
      mid();
      chk("rm_byte1", 32'(rr_a), 32'h4);
      nxt(); tx_rdy = 1'b0; rst = 1'b1;
      mid();
      nxt(); rst = 1'b0; val = 4'b1111;
      mid();
      chk("rm_busy", 32'(busy_a), 32'd0);
      chk("rm_txval", 32'(txv_a), 32'd0);
      chk("rm_owner", 32'(own_a), 32'd0);
      nxt();
      mid();
      chk("rm_regrant_owner", 32'(own_a), 32'd0);
      chk("rm_regrant_busy", 32'(busy_a), 32'd1);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
